// File: rtl/ifetch_pkg.sv
// ifetch_pkg
// Shared types and constants for the instruction fetch stage.
//   state_e        : fetch FSM states (IDLE / REQ / VALID / HALT)
//   PC_SEQ..PC_REG : encodings of the pcWrite redirect select
//   *_MSB / *_LSB  : MIPS instruction field positions
// The misaligned-jr trap feature is controlled by the IFETCH_MISALIGN_TRAP_EN
// macro (see instruction_fetch.sv).
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int IMM_MSB    = 15;
    localparam int TARGET_MSB = 25;

endpackage

// File: rtl/instruction_fetch_next_pc_calc.sv
// next_pc_calc
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pc          in  32 : address of the instruction being retired
//   instruction in  26 : low instruction bits (jump index / branch immediate)
//   pcWrite     in   2 : redirect select (seq / branch / jump / register)
//   branchTaken in   1 : branch condition, only used with PC_BRANCH
//   regTarget   in  32 : jr target
//   nextPc      out 32 : selected next PC (jr target forced word aligned)
//   misaligned  out  1 : regTarget low two bits non-zero
// The macro IFETCH_MISALIGN_TRAP_EN does not affect this block; trapping is
// decided in the top level.
module next_pc_calc
    import ifetch_pkg::*;
(
    input  logic [31:0]         pc,
    input  logic [TARGET_MSB:0] instruction,
    input  logic [1:0]          pcWrite,
    input  logic                branchTaken,
    input  logic [31:0]         regTarget,
    output logic [31:0]         nextPc,
    output logic                misaligned
);

    logic [31:0] pc4;
    logic [31:0] branch_offset;

    assign pc4           = pc + 32'd4;
    // Word offset: sign-extended 16-bit immediate scaled by 4.
    assign branch_offset = {{14{instruction[IMM_MSB]}}, instruction[IMM_MSB:0], 2'b00};
    assign misaligned    = |regTarget[1:0];

    always_comb begin
        nextPc = pc4;
        case (pcWrite)
            PC_BRANCH: if (branchTaken) nextPc = pc4 + branch_offset;
            PC_JUMP:   nextPc = {pc4[31:28], instruction[TARGET_MSB:0], 2'b00};
            PC_REG:    nextPc = {regTarget[31:2], 2'b00};
            default:   nextPc = pc4;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
// Fetch stage: owns the PC, reads instruction words over a req/ready
// handshake, holds the fetched word stable until execute accepts it, then
// applies the redirect returned by the controller. syscall parks in HALT.
//
// state | meaning
// IDLE  | just out of reset, request starts on the next edge
// REQ   | imemReq high with imemAddr = pc, waiting for imemReady
// VALID | instruction held, waiting for instrAccept
// HALT  | parked after syscall (or jr trap); resume re-enters REQ
//
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   imemReq/imemAddr            : fetch request and word address (= pc)
//   imemReady/imemData          : memory response
//   instrValid/instruction/operator/special/pc : held instruction
//   instrAccept                 : execute consumes instruction, redirects sampled
//   pcWrite/branchTaken/regTarget : redirect controls
//   halt/resume/halted          : syscall halt control
//   fault                       : misaligned jr trapped (sticky until reset)
// Build option: define IFETCH_MISALIGN_TRAP_EN to trap misaligned jr targets
// instead of silently clearing their low two bits.
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic        instrValid,
    input  logic        instrAccept,
    output logic [31:0] instruction,
    output logic [5:0]  operator,
    output logic [5:0]  special,
    output logic [31:0] pc,
    input  logic [1:0]  pcWrite,
    input  logic        branchTaken,
    input  logic [31:0] regTarget,
    input  logic        halt,
    input  logic        resume,
    output logic        halted,
    output logic        fault
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] next_pc;
    logic        misaligned;
    logic        trap_jr;

    next_pc_calc u_next_pc_calc (
        .pc          (pc_q),
        .instruction (instr_q[TARGET_MSB:0]),
        .pcWrite     (pcWrite),
        .branchTaken (branchTaken),
        .regTarget   (regTarget),
        .nextPc      (next_pc),
        .misaligned  (misaligned)
    );

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;

    assign trap_jr = misaligned && (pcWrite == PC_REG);
    assign fault_d = fault_q || ((state_q == VALID) && instrAccept && trap_jr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end

    assign fault = fault_q;
`else
    logic unused_misaligned;

    assign unused_misaligned = misaligned;
    assign trap_jr           = 1'b0;
    assign fault             = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        imemReq    = 1'b0;
        instrValid = 1'b0;
        halted     = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                imemReq = 1'b1;
                if (imemReady) begin
                    instr_d = imemData;
                    state_d = VALID;
                end
            end
            VALID: begin
                instrValid = 1'b1;
                if (instrAccept) begin
                    // A trapped jr keeps the pc on the offending instruction.
                    if (trap_jr) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = halt ? HALT : REQ;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
                if (resume && !fault) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imemAddr    = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign operator    = instr_q[OP_MSB:OP_LSB];
    assign special     = instr_q[FUNCT_MSB:0];

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic        instrValid;
    logic        instrAccept;
    logic [31:0] instruction;
    logic [5:0]  operator;
    logic [5:0]  special;
    logic [31:0] pc;
    logic [1:0]  pcWrite;
    logic        branchTaken;
    logic [31:0] regTarget;
    logic        halt;
    logic        resume;
    logic        halted;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_fault;
    logic        m_halted;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemReady   (imemReady),
        .imemData    (imemData),
        .instrValid  (instrValid),
        .instrAccept (instrAccept),
        .instruction (instruction),
        .operator    (operator),
        .special     (special),
        .pc          (pc),
        .pcWrite     (pcWrite),
        .branchTaken (branchTaken),
        .regTarget   (regTarget),
        .halt        (halt),
        .resume      (resume),
        .halted      (halted),
        .fault       (fault)
    );

    // Next PC straight from the MIPS rules, in plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input logic [1:0] sel, input logic taken,
                                             input logic [31:0] tgt);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        off = int'($signed(ins[15:0])) * 4;
        case (sel)
            2'd0:    return seq;
            2'd1:    return taken ? seq + 32'(off) : seq;
            2'd2:    return (seq & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
            default: return tgt & 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic clear_inputs();
        imemReady   = 1'b0;
        imemData    = $urandom;
        instrAccept = 1'b0;
        pcWrite     = 2'b00;
        branchTaken = 1'b0;
        regTarget   = $urandom;
        halt        = 1'b0;
        resume      = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] data, input int waits, input string tag);
        int k;
        k = 0;
        while (imemReq !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (imemReq !== 1'b1) begin
            n_errors++;
            $display("FAIL %s req_timeout: imemReq=%b expected 1", tag, imemReq);
        end
        n_checks++;
        if (imemAddr !== m_pc) begin
            n_errors++;
            $display("FAIL %s imemAddr: got %h expected %h", tag, imemAddr, m_pc);
        end
        for (int w = 0; w < waits; w++) begin
            // Noise on inputs that must be ignored while requesting.
            imemReady   = 1'b0;
            imemData    = $urandom;
            instrAccept = 1'($urandom_range(0, 1));
            pcWrite     = 2'($urandom);
            halt        = 1'($urandom_range(0, 1));
            resume      = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++;
            if (imemReq !== 1'b1 || instrValid !== 1'b0 || imemAddr !== m_pc) begin
                n_errors++;
                $display("FAIL %s wait%0d: req=%b valid=%b addr=%h expected req=1 valid=0 addr=%h",
                         tag, w, imemReq, instrValid, imemAddr, m_pc);
            end
        end
        clear_inputs();
        imemReady = 1'b1;
        imemData  = data;
        @(negedge clk);
        clear_inputs();
        m_instr = data;
        n_checks++;
        if (instrValid !== 1'b1 || imemReq !== 1'b0) begin
            n_errors++;
            $display("FAIL %s valid: valid=%b req=%b expected valid=1 req=0", tag, instrValid, imemReq);
        end
        n_checks++;
        if (instruction !== data || operator !== data[31:26] || special !== data[5:0]) begin
            n_errors++;
            $display("FAIL %s instr: got %h op=%b fn=%b expected %h", tag, instruction, operator, special, data);
        end
        n_checks++;
        if (pc !== m_pc) begin
            n_errors++;
            $display("FAIL %s pc: got %h expected %h", tag, pc, m_pc);
        end
    endtask

    task automatic do_accept(input logic [1:0] sel, input logic taken, input logic [31:0] tgt,
                             input logic hlt, input string tag);
        logic [31:0] exp_pc;
        logic        trap;
        int          stall;
        trap = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        trap = (sel == 2'b11) && (tgt[1:0] != 2'b00);
`endif
        exp_pc = trap ? m_pc : ref_next(m_pc, m_instr, sel, taken, tgt);
        stall = $urandom_range(0, 2);
        for (int s = 0; s < stall; s++) begin
            imemReady = 1'($urandom_range(0, 1));
            imemData  = $urandom;
            resume    = 1'($urandom_range(0, 1));
            halt      = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++;
            if (instrValid !== 1'b1 || instruction !== m_instr || pc !== m_pc) begin
                n_errors++;
                $display("FAIL %s stall: valid=%b instr=%h pc=%h expected valid=1 instr=%h pc=%h",
                         tag, instrValid, instruction, pc, m_instr, m_pc);
            end
        end
        clear_inputs();
        instrAccept = 1'b1;
        pcWrite     = sel;
        branchTaken = taken;
        regTarget   = tgt;
        halt        = hlt;
        @(negedge clk);
        clear_inputs();
        m_pc     = exp_pc;
        m_fault  = m_fault | trap;
        m_halted = hlt | trap;
        n_checks++;
        if (pc !== m_pc) begin
            n_errors++;
            $display("FAIL %s next_pc: got %h expected %h", tag, pc, m_pc);
        end
        n_checks++;
        if (m_halted) begin
            if (halted !== 1'b1 || imemReq !== 1'b0 || instrValid !== 1'b0 || fault !== m_fault) begin
                n_errors++;
                $display("FAIL %s halt_state: halted=%b req=%b valid=%b fault=%b expected 1 0 0 %b",
                         tag, halted, imemReq, instrValid, fault, m_fault);
            end
        end else begin
            if (imemReq !== 1'b1 || instrValid !== 1'b0 || halted !== 1'b0 || imemAddr !== m_pc) begin
                n_errors++;
                $display("FAIL %s refetch: req=%b valid=%b halted=%b addr=%h expected 1 0 0 %h",
                         tag, imemReq, instrValid, halted, imemAddr, m_pc);
            end
        end
    endtask

    task automatic do_resume(input string tag);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        n_checks++;
        if (m_fault) begin
            if (halted !== 1'b1 || imemReq !== 1'b0) begin
                n_errors++;
                $display("FAIL %s resume_blocked: halted=%b req=%b expected 1 0", tag, halted, imemReq);
            end
        end else begin
            m_halted = 1'b0;
            if (halted !== 1'b0 || imemReq !== 1'b1 || imemAddr !== m_pc) begin
                n_errors++;
                $display("FAIL %s resume: halted=%b req=%b addr=%h expected 0 1 %h",
                         tag, halted, imemReq, imemAddr, m_pc);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (pc !== 32'h0 || instruction !== 32'h0 || operator !== 6'h0 || special !== 6'h0) begin
            n_errors++;
            $display("FAIL %s rst_regs: pc=%h instr=%h op=%h fn=%h expected all 0", tag, pc, instruction, operator, special);
        end
        n_checks++;
        if (imemReq !== 1'b0 || instrValid !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
            n_errors++;
            $display("FAIL %s rst_ctl: req=%b valid=%b halted=%b fault=%b expected all 0",
                     tag, imemReq, instrValid, halted, fault);
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        clear_inputs();
        imemReady = 1'b1; // late response during reset must be ignored
        repeat (2) @(negedge clk);
        check_reset_values(tag);
        rst_n = 1'b1;
        @(negedge clk);
        imemReady = 1'b0;
        m_pc     = 32'h0;
        m_instr  = 32'h0;
        m_fault  = 1'b0;
        m_halted = 1'b0;
        n_checks++;
        if (imemReq !== 1'b1 || instrValid !== 1'b0 || imemAddr !== 32'h0) begin
            n_errors++;
            $display("FAIL %s first_req: req=%b valid=%b addr=%h expected 1 0 0", tag, imemReq, instrValid, imemAddr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imemReq !== 1'b0) begin
            n_errors++;
            $display("FAIL reset idle_req: got %b expected 0", imemReq);
        end
        @(negedge clk);
        m_pc = 32'h0; m_fault = 1'b0; m_halted = 1'b0; m_instr = 32'h0;
        n_checks++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
            n_errors++;
            $display("FAIL reset first_req: req=%b addr=%h expected 1 0", imemReq, imemAddr);
        end
    endtask

    task automatic test_zero_wait();
        do_fetch(32'h2008_0005, 0, "zero_wait");
        n_checks++;
        if (operator !== 6'b001000) begin
            n_errors++;
            $display("FAIL zero_wait operator: got %b expected 001000", operator);
        end
        do_accept(2'b00, 1'b0, 32'h0, 1'b0, "zero_wait");
        n_checks++;
        if (imemAddr !== 32'h4) begin
            n_errors++;
            $display("FAIL zero_wait addr4: got %h expected 00000004", imemAddr);
        end
    endtask

    task automatic test_wait_states();
        do_fetch(32'h0000_0020, 3, "wait3");
        do_accept(2'b11, 1'b0, 32'h0000_0010, 1'b0, "wait3_jr");
    endtask

    task automatic test_branch();
        logic [31:0] beq;
        beq = {6'h04, 5'd1, 5'd2, 16'hFFFC};
        do_fetch(beq, 0, "beq_taken");
        do_accept(2'b01, 1'b1, 32'h0, 1'b0, "beq_taken");
        n_checks++;
        if (imemAddr !== 32'h4) begin
            n_errors++;
            $display("FAIL beq_taken addr: got %h expected 00000004", imemAddr);
        end
        do_fetch(32'h0000_0008, 1, "beq_back");
        do_accept(2'b11, 1'b0, 32'h0000_0010, 1'b0, "beq_back");
        do_fetch(beq, 2, "beq_not");
        do_accept(2'b01, 1'b0, 32'h0, 1'b0, "beq_not");
        n_checks++;
        if (imemAddr !== 32'h14) begin
            n_errors++;
            $display("FAIL beq_not addr: got %h expected 00000014", imemAddr);
        end
    endtask

    task automatic test_jump();
        do_fetch(32'h0000_0008, 0, "jump_setup");
        do_accept(2'b11, 1'b0, 32'hF000_0000, 1'b0, "jump_setup");
        do_fetch({6'h02, 26'h000_0040}, 1, "j");
        do_accept(2'b10, 1'b0, 32'h0, 1'b0, "j");
        n_checks++;
        if (imemAddr !== 32'hF000_0100) begin
            n_errors++;
            $display("FAIL j addr: got %h expected f0000100", imemAddr);
        end
        do_fetch(32'h0060_0008, 0, "jr");
        do_accept(2'b11, 1'b0, 32'h0000_0200, 1'b0, "jr");
        n_checks++;
        if (imemAddr !== 32'h200) begin
            n_errors++;
            $display("FAIL jr addr: got %h expected 00000200", imemAddr);
        end
    endtask

    task automatic test_halt();
        do_fetch(32'h0000_000C, 0, "syscall");
        do_accept(2'b00, 1'b0, 32'h0, 1'b1, "syscall");
        for (int c = 0; c < 5; c++) begin
            instrAccept = 1'($urandom_range(0, 1));
            imemReady   = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++;
            if (halted !== 1'b1 || imemReq !== 1'b0 || pc !== 32'h204) begin
                n_errors++;
                $display("FAIL halt hold%0d: halted=%b req=%b pc=%h expected 1 0 00000204", c, halted, imemReq, pc);
            end
        end
        clear_inputs();
        do_resume("syscall");
        n_checks++;
        if (imemAddr !== 32'h204) begin
            n_errors++;
            $display("FAIL halt resume_addr: got %h expected 00000204", imemAddr);
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        logic        hlt;
        for (int i = 0; i < 40; i++) begin
            do_fetch($urandom, $urandom_range(0, 3), "rand");
            tgt = $urandom;
`ifdef IFETCH_MISALIGN_TRAP_EN
            tgt[1:0] = 2'b00;
`endif
            hlt = ($urandom_range(0, 5) == 0);
            do_accept(2'($urandom), 1'($urandom_range(0, 1)), tgt, hlt, "rand");
            if (m_halted) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                do_resume("rand");
            end
        end
    endtask

    task automatic test_reset_mid_req();
        do_fetch(32'h1234_5678, 0, "mid_req");
        do_accept(2'b00, 1'b0, 32'h0, 1'b0, "mid_req");
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (imemReq !== 1'b0 || pc !== 32'h0) begin
            n_errors++;
            $display("FAIL mid_req async: req=%b pc=%h expected 0 0", imemReq, pc);
        end
        do_reset("mid_req");
        do_fetch(32'h2008_0005, 0, "after_reset");
        do_accept(2'b00, 1'b0, 32'h0, 1'b0, "after_reset");
    endtask

    task automatic test_jr_misaligned();
        do_fetch(32'h03E0_0008, 0, "jr_mis");
        do_accept(2'b11, 1'b0, 32'h0000_0202, 1'b0, "jr_mis");
`ifdef IFETCH_MISALIGN_TRAP_EN
        n_checks++;
        if (fault !== 1'b1 || halted !== 1'b1 || pc !== 32'h4) begin
            n_errors++;
            $display("FAIL jr_mis trap: fault=%b halted=%b pc=%h expected 1 1 00000004", fault, halted, pc);
        end
        do_resume("jr_mis");
        do_reset("jr_mis_clear");
`else
        n_checks++;
        if (fault !== 1'b0 || imemAddr !== 32'h200) begin
            n_errors++;
            $display("FAIL jr_mis align: fault=%b addr=%h expected 0 00000200", fault, imemAddr);
        end
`endif
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        m_pc = 32'h0; m_instr = 32'h0; m_fault = 1'b0; m_halted = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch();
        test_jump();
        test_halt();
        test_random();
        test_reset_mid_req();
        test_jr_misaligned();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the single-cycle-style MIPS core: owns the PC, issues word reads to instruction memory over a req/ready handshake, and holds the fetched instruction plus its decoded `operator` and `special` fields stable for the Controller and execute logic. On each accepted instruction it computes the next PC from the redirect controls returned by the Controller path (`pcWrite`, branch/jump/jr targets). It also parks the core on `syscall` halt until resumed.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word aligned.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imemReq` out 1: read request; held with stable `imemAddr` until `imemReady`.
- `imemAddr` out 32: byte address of the word to fetch (= `pc`).
- `imemReady` in 1: memory has `imemData` valid this cycle; ignored unless `imemReq`.
- `imemData` in 32: instruction word.
- `instrValid` out 1: `instruction`/`operator`/`special`/`pc` valid.
- `instrAccept` in 1: execute consumes the instruction this cycle; redirect inputs sampled now.
- `instruction` out 32: registered instruction word.
- `operator` out 6: `instruction[31:26]`.
- `special` out 6: `instruction[5:0]`.
- `pc` out 32: address of the current instruction.
- `pcWrite` in 2: 00 sequential, 01 branch, 10 jump (j/jal), 11 register (jr).
- `branchTaken` in 1: branch condition true (only meaningful with `pcWrite`=01).
- `regTarget` in 32: jr target.
- `halt` in 1: syscall halt request, sampled with `instrAccept`.
- `resume` in 1: leave HALT.
- `halted` out 1: in HALT.
- `fault` out 1: misaligned jr target trapped (see Configuration).

## Operation
- States: IDLE, REQ, VALID, HALT.
- IDLE: entered on reset; first rising edge with `rst_n` high -> REQ.
- REQ: `imemReq`=1, `imemAddr`=`pc`. On edge with `imemReady`=1: capture `imemData` into `instruction`, -> VALID.
- VALID: `instrValid`=1, outputs frozen. On edge with `instrAccept`=1: `pc` <= next PC; -> HALT if `halt`, else -> REQ.
- HALT: `halted`=1, no requests, `pc` already holds next PC. On edge with `resume`=1 -> REQ.
- Next PC (pc4 = pc+4, all arithmetic mod 2^32, wrap silently):
  - 00, or 01 with `branchTaken`=0: pc4.
  - 01 with `branchTaken`=1: pc4 + (signext(instruction[15:0]) << 2).
  - 10: {pc4[31:28], instruction[25:0], 2'b00}.
  - 11: `regTarget` (alignment per Configuration).
- Ignored inputs: `instrAccept` outside VALID; `resume` outside HALT; `halt`/`pcWrite`/`branchTaken` without `instrAccept`; `imemReady` outside REQ.
- `halt` and a redirect in the same accept: redirect applied to `pc`, then HALT.

## Timing
- Reset values: `pc`=RESET_PC, `instruction`=0 (so `operator`/`special`=0), `imemReq`=0, `instrValid`=0, `halted`=0, `fault`=0.
- `imemReq` first high in the cycle after the first post-reset edge.
- Zero-wait memory: `imemReady` high in first REQ cycle -> `instrValid` next cycle; minimum 2 cycles/instruction with same-cycle accept.
- `instrValid` falls and `imemReq` rises on the same edge following accept.
- Reset mid-REQ aborts; a late `imemReady` after reset is ignored (state IDLE).

## Configuration
- `IFETCH_MISALIGN_TRAP_EN` defined: jr with `regTarget[1:0]`≠0 -> `pc` unchanged, `fault`=1, -> HALT; `fault` cleared only by reset (`resume` ignored while `fault`=1).
- Undefined: jr target low two bits forced to 00; `fault` tied 0.

## Structure
- Package `ifetch_pkg`: state enum (IDLE/REQ/VALID/HALT), `PC_SEQ`/`PC_BRANCH`/`PC_JUMP`/`PC_REG` 2-bit constants, field slice constants (OP_MSB=31, OP_LSB=26, FUNCT_MSB=5, IMM_MSB=15, TARGET_MSB=25).
- One combinational sub-module `next_pc_calc` (pc, instruction, pcWrite, branchTaken, regTarget -> nextPc, misaligned).

## Test plan
- Reset, zero-wait memory returning 32'h2008_0005 at 0, accept with `pcWrite`=00 -> `operator`=6'b001000, next `imemAddr`=32'h4.
- Memory with 3 wait cycles -> `imemReq`/`imemAddr` stable 3 cycles, `instrValid` one cycle after `imemReady`.
- beq at pc=32'h10 imm=16'hFFFC, `branchTaken`=1 -> next addr 32'h4; `branchTaken`=0 -> 32'h14.
- j at pc=32'hF000_0000 target 26'h000_0040 -> next addr 32'hF000_0100; jr `regTarget`=32'h0000_0200 -> 32'h200.
- syscall accept with `halt`=1 -> `halted`=1, no `imemReq` for 5 cycles; `resume` pulse -> request at pc+4.
- jr `regTarget`=32'h202: with macro -> `fault`=1, HALT, `pc` unchanged; without -> next addr 32'h200.
